// File: rtl/samm_pkg.sv
// Shared types and sizes for the samm systolic matrix multiplier.
// Element width, array size and result packing live here.
package samm_pkg;

  localparam int N     = 8;
  localparam int M     = 8;
  localparam int ACC_W = 2 * N;
  localparam int IN_W  = 2 * M * N;
  localparam int OUT_W = N * 2 * M * M;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2 * M - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/samm_pe.sv
// One processing element: forwards a right and b down,
// accumulating a*b on valid beats.
module samm_pe
  import samm_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  input  logic             v_in,
  input  logic             Sclr,
  output logic [N-1:0]     a_out,
  output logic [N-1:0]     b_out,
  output logic             v_out,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] prod;

  assign prod = ACC_W'(a_in) * ACC_W'(b_in);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_out <= '0;
      b_out <= '0;
      v_out <= 1'b0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      v_out <= v_in;
      // Sclr rides with the first beat so the old sum is dropped in place
      if (v_in) acc <= (Sclr ? '0 : acc) + prod;
    end
  end

endmodule

// File: rtl/samm.sv
// Output-stationary M x M systolic matrix multiplier top:
// input register, skew lines, burst FSM and result register.
module samm
  import samm_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Dv,
  input  logic [IN_W-1:0]  A,
  output logic [OUT_W-1:0] Out_data,
  output logic             Out_Dv
);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             load;
  logic             sclr_new;

  logic [N-1:0]     data_a [M];
  logic [N-1:0]     data_b [M];
  logic             data_v;
  logic             sclr_p [2*M-1];

  logic [N-1:0]     a_h [M][M+1];
  logic             v_h [M][M+1];
  logic [N-1:0]     b_v [M+1][M];
  logic [ACC_W-1:0] acc_m [M][M];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_v <= 1'b0;
      for (int i = 0; i < M; i++) begin
        data_a[i] <= '0;
        data_b[i] <= '0;
      end
    end else begin
      data_v <= In_Dv;
      for (int i = 0; i < M; i++) begin
        data_a[i] <= In_Dv ? A[i*N +: N] : '0;
        data_b[i] <= In_Dv ? A[M*N + i*N +: N] : '0;
      end
    end
  end

  // clear flag follows the beat diagonally, one stage per i+j
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < 2*M-1; k++) sclr_p[k] <= 1'b0;
    end else begin
      sclr_p[0] <= sclr_new;
      for (int k = 1; k < 2*M-1; k++) sclr_p[k] <= sclr_p[k-1];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    if (i == 0) begin : g_nod
      assign a_h[0][0] = data_a[0];
      assign v_h[0][0] = data_v;
    end else begin : g_dly
      logic [N-1:0] sa [i];
      logic         sv [i];
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int k = 0; k < i; k++) begin
            sa[k] <= '0;
            sv[k] <= 1'b0;
          end
        end else begin
          sa[0] <= data_a[i];
          sv[0] <= data_v;
          for (int k = 1; k < i; k++) begin
            sa[k] <= sa[k-1];
            sv[k] <= sv[k-1];
          end
        end
      end
      assign a_h[i][0] = sa[i-1];
      assign v_h[i][0] = sv[i-1];
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_col
    if (j == 0) begin : g_nod
      assign b_v[0][0] = data_b[0];
    end else begin : g_dly
      logic [N-1:0] sb [j];
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int k = 0; k < j; k++) sb[k] <= '0;
        end else begin
          sb[0] <= data_b[j];
          for (int k = 1; k < j; k++) sb[k] <= sb[k-1];
        end
      end
      assign b_v[0][j] = sb[j-1];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_pe_r
    for (genvar j = 0; j < M; j++) begin : g_pe_c
      samm_pe u_pe (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .v_in  (v_h[i][j]),
        .Sclr  (sclr_p[i+j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .v_out (v_h[i][j+1]),
        .acc   (acc_m[i][j])
      );
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    load     = 1'b0;
    sclr_new = 1'b0;
    unique case (state)
      IDLE: begin
        if (In_Dv) begin
          state_n  = LOAD;
          sclr_new = 1'b1;
        end
      end
      LOAD: begin
        if (!In_Dv) begin
          state_n = DRAIN;
          count_n = '0;
        end
      end
      DRAIN: begin
        if (In_Dv) begin
          state_n = LOAD;
        end else if (count == CNT_END) begin
          state_n = IDLE;
        end else begin
          count_n = sat_inc(count);
          // last PE settles one edge before this one
          load    = (count == CNT_END - CNT_W'(1));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_Dv   <= 1'b0;
      Out_data <= '0;
    end else begin
      Out_Dv <= load;
      if (load) begin
        for (int i = 0; i < M; i++) begin
          for (int j = 0; j < M; j++) begin
            Out_data[(i*M+j)*ACC_W +: ACC_W] <= acc_m[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_samm.sv
// Directed and randomized bench for samm against a
// sum-of-outer-products model with fixed output latency.
module tb_samm;
  import samm_pkg::*;

  logic             Clk;
  logic             Rst_n;
  logic             In_Dv;
  logic [IN_W-1:0]  A;
  logic [OUT_W-1:0] Out_data;
  logic             Out_Dv;

  int checks;
  int failures;

  logic [15:0] exp_c [8][8];

  samm dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .In_Dv    (In_Dv),
    .A        (A),
    .Out_data (Out_data),
    .Out_Dv   (Out_Dv)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag,
                         input logic [1023:0] obs);
    int bad;
    int idx;
    logic [15:0] o;
    logic [15:0] e;
    bad = 0;
    idx = 0;
    o = '0;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (obs[(i*8+j)*16 +: 16] !== exp_c[i][j]) begin
          if (bad == 0) begin
            idx = i * 8 + j;
            o = obs[(i*8+j)*16 +: 16];
            e = exp_c[i][j];
          end
          bad++;
        end
      end
    end
    checks++;
    assert (bad == 0) else begin
      failures++;
      $error("FAIL %s entry=%0d observed=%0h expected=%0h bad=%0d",
             tag, idx, o, e, bad);
    end
  endtask

  function automatic logic [127:0] make_vec(input int mode);
    logic [127:0] v;
    v = '0;
    case (mode)
      0: v = 128'h00000000010101010000000001010101;
      1: for (int i = 0; i < 8; i++) begin
           v[i*8 +: 8]      = 8'(i + 1);
           v[64 + i*8 +: 8] = 8'(i + 1);
         end
      2: v = '1;
      default: v = rnd128();
    endcase
    return v;
  endfunction

  task automatic send_beats(input int k, input int mode,
                            input int max_gap, output int early);
    logic [127:0] v;
    int ai;
    int bj;
    early = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) exp_c[i][j] = '0;
    for (int b = 0; b < k; b++) begin
      if (b > 0 && max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        for (int t = 0; t < g; t++) begin
          In_Dv = 1'b0;
          A = rnd128();
          @(posedge Clk); #1;
          if (Out_Dv) early++;
        end
      end
      v = make_vec(mode);
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          ai = int'(v[i*8 +: 8]);
          bj = int'(v[64 + j*8 +: 8]);
          exp_c[i][j] = exp_c[i][j] + 16'(ai * bj);
        end
      end
      A = v;
      In_Dv = 1'b1;
      @(posedge Clk); #1;
      if (Out_Dv) early++;
    end
    In_Dv = 1'b0;
    A = rnd128();
  endtask

  task automatic run_burst(input string tag, input int k,
                           input int mode, input int max_gap);
    int early;
    int first;
    int pulses;
    logic [1023:0] snap;
    send_beats(k, mode, max_gap, early);
    first = -1;
    pulses = 0;
    snap = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      A = rnd128();
      if (Out_Dv) begin
        pulses++;
        if (first < 0) begin
          first = n;
          snap = Out_data;
        end
      end
    end
    chk({tag, "_early"}, early, 0);
    chk({tag, "_lat"}, first, 16);
    chk({tag, "_pulses"}, pulses, 1);
    chk_mat({tag, "_data"}, snap);
    chk_mat({tag, "_hold"}, Out_data);
  endtask

  task automatic pulse_reset();
    #3;
    Rst_n = 1'b0;
    #1;
    chk("rst_dv", Out_Dv, 0);
    chk("rst_data", 32'(|Out_data), 0);
    #39;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  initial begin
    int cnt;
    int early;
    checks = 0;
    failures = 0;
    Rst_n = 1'b0;
    In_Dv = 1'b0;
    A = '0;

    #35;
    chk("init_dv", Out_Dv, 0);
    chk("init_data", 32'(|Out_data), 0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      A = rnd128();
      @(posedge Clk); #1;
      if (Out_Dv) cnt++;
    end
    chk("idle_dv", cnt, 0);
    chk("idle_data", 32'(|Out_data), 0);

    run_burst("pat", 8, 0, 0);
    chk("pat_c33", Out_data[(3*8+3)*16 +: 16], 32'h8);
    chk("pat_c44", Out_data[(4*8+4)*16 +: 16], 32'h0);
    chk("pat_c07", Out_data[(0*8+7)*16 +: 16], 32'h0);

    for (int r = 0; r < 5; r++) begin
      pulse_reset();
      run_burst("rep", 8, 0, 0);
    end

    run_burst("one", 1, 1, 0);
    chk("one_c77", Out_data[63*16 +: 16], 32'd64);
    chk("one_c25", Out_data[(2*8+5)*16 +: 16], 32'd18);

    run_burst("ovf", 2, 2, 0);
    chk("ovf_c00", Out_data[15:0], 32'hFC02);
    chk("ovf_c77", Out_data[63*16 +: 16], 32'hFC02);

    for (int r = 0; r < 6; r++) begin
      run_burst("rnd", $urandom_range(6, 1), 3, 6);
    end

    run_burst("pre", 4, 3, 0);
    send_beats(3, 3, 0, early);
    for (int n = 0; n < 5; n++) begin
      @(posedge Clk); #1;
    end
    pulse_reset();
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge Clk); #1;
      if (Out_Dv) cnt++;
    end
    chk("drain_rst_dv", cnt, 0);
    chk("drain_rst_data", 32'(|Out_data), 0);

    run_burst("post", 5, 3, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/samm.md
Name: samm

Overview:
- Output-stationary M x M systolic-array matrix multiplier over unsigned N-bit operands.
- Each valid beat carries one column vector a (M elements, left operand) and one row vector b (M elements, right operand).
- PE(i,j) accumulates a[i]*b[j] over all beats of a burst, forming C = sum over k of a_k * b_k^T.
- It is a streaming compute tile; the full 2N-bit result matrix is presented with a single-cycle valid strobe.

Parameters:
- N, 8, operand element width in bits.
- M, 8, array dimension (M x M PEs, M elements per vector).

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- In_Dv  in  1  input beat valid.
- A  in  2*M*N  element a[i] = A[i*N +: N]; element b[j] = A[M*N + j*N +: N].
- Out_data  out  N*2*M*M  C[i][j] = Out_data[(i*M+j)*2N +: 2N].
- Out_Dv  out  1  one-cycle strobe; Out_data valid and updated this cycle.

Behaviour:
- Reset (async, Rst_n=0):
  - All skew registers, PE registers, accumulators, count and state clear to 0; state = IDLE.
  - Out_Dv=0; Out_data=0.
  - Reset mid-burst or mid-drain discards the partial result; no Out_Dv is produced for it.
- Input stage: A is registered (data_A) on every edge where In_Dv=1; a zero/invalid marker enters when In_Dv=0.
- Skew:
  - Element a[i] is delayed i extra cycles before entering row i.
  - Element b[j] is delayed j extra cycles before entering column j.
  - PE(i,j) therefore sees beat k at cycle k+1+i+j.
- PE(i,j):
  - Passes a rightward (Pwire_hor, N bits) and b downward, with a valid flag, one register stage each.
  - On valid: acc <= acc + a*b.
  - Product is 2N bits; acc is 2N bits, unsigned, wraps mod 2^(2N).
- State machine (IDLE, LOAD, DRAIN):
  - IDLE --In_Dv=1--> LOAD; this first beat asserts Sclr, which zeroes all accumulators as that beat's data enters.
  - LOAD --In_Dv=0--> DRAIN; count resets to 0.
  - DRAIN:
    - count increments each cycle.
    - If In_Dv=1 re-asserts, return to LOAD without clearing; the burst is extended and accumulation continues.
    - When count = 2*M-1, go to IDLE.
- Output latency:
  - Out_Dv pulses high exactly 2*M cycles after the edge that sampled the last valid beat (16 cycles for M=8).
  - Out_data is registered from the accumulators on that edge.
  - Out_data holds its value until the next Out_Dv or reset.
- count: 8 bits, saturating; 2*M must be ≤ 255.
- Burst length K is unbounded; results wrap per the width rule.
- Single-beat burst (K=1): C = a*b^T with the same 2*M latency.

Decomposition:
- Package samm_pkg: state enum (IDLE, LOAD, DRAIN); localparams ACC_W=2*N, OUT_W=N*2*M*M.
- Sub-module samm_pe, instantiated M*M times via generate:
  - Inputs: a_in, b_in, v_in, Sclr.
  - Outputs: a_out, b_out, v_out, acc.
- Top level contains the input register, skew delay lines, FSM/count and the output register.

Test Plan:
- Reset: hold Rst_n=0 for 35 ns -> Out_Dv=0, Out_data=0. Release, keep In_Dv=0 for 500 ns -> Out_Dv never asserts.
- 8-beat burst, A=128'h00000000010101010000000001010101 every beat (a[0..3]=1, a[4..7]=0, same for b) -> one Out_Dv pulse 16 cycles after the last beat. C[i][j]=16'h0008 for i,j<4; all other entries 0.
- Repeat the same burst 5 times with a mid-gap reset (Rst_n low 40 ns) -> each burst yields an identical Out_data (accumulators cleared, no carry-over) and exactly one Out_Dv.
- Single beat with a[i]=i+1, b[j]=j+1 -> C[i][j]=(i+1)*(j+1); Out_Dv at cycle +16.
- Overflow: a=b=8'hFF on all lanes for 2 beats -> each C = 2*0xFE01 mod 2^16 = 16'hFC02.
- Async reset asserted during DRAIN -> Out_Dv never fires for that burst; outputs are 0 immediately, without waiting for a clock edge.
